tt_vpu_ovi_store_ctrl: RTL and testbench

TT_VPU_OVI_STORE_CTRL -- requirements
Module: tt_vpu_ovi_store_ctrl

---
 rtl/tt_vpu_ovi_pkg.sv | 20 ++
 rtl/tt_vpu_store_buf.sv | 69 ++++++
 rtl/tt_vpu_ovi_store_ctrl.sv | 176 +++++++++++++++++
 tb/tb_tt_vpu_ovi_store_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_vpu_ovi_pkg.sv
// Shared types and constants for the VPU OVI store path.
//   store_state_e     : store controller FSM states
//   OVI_STORE_DATA_W  : width of one OVI store-data beat
//   OVI_HALF_W        : bit offset of the second entry inside a beat
//   DEFAULT_STORE_CREDITS : store-data credits granted by the CPU after reset
package tt_vpu_ovi_pkg;

    localparam int unsigned OVI_STORE_DATA_W      = 512;
    localparam int unsigned OVI_HALF_W            = 256;
    localparam int unsigned DEFAULT_STORE_CREDITS = 32;

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StDrain,
        StSync,
        StWaitLq
    } store_state_e;

endpackage

// File: rtl/tt_vpu_store_buf.sv
// Circular buffer of BUF_DEPTH entries, VLEN bits each, holding vs3 slices until
// they are shipped as OVI beats.
//   i_clk, i_reset   : clock, synchronous active-high reset
//   i_clear          : zero pointers and occupancy (start of a new store)
//   i_push/i_push_data : write one entry at the write pointer
//   i_pop1/i_pop2    : retire one or two entries from the head (mutually exclusive)
//   o_head0/o_head1  : oldest and second-oldest entries
//   o_count          : occupancy, 0..BUF_DEPTH
module tt_vpu_store_buf #(
    parameter int unsigned VLEN      = 256,
    parameter int unsigned BUF_DEPTH = 8
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_clear,
    input  logic                           i_push,
    input  logic [VLEN-1:0]                i_push_data,
    input  logic                           i_pop1,
    input  logic                           i_pop2,
    output logic [VLEN-1:0]                o_head0,
    output logic [VLEN-1:0]                o_head1,
    output logic [$clog2(BUF_DEPTH):0]     o_count
);

    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [VLEN-1:0]  mem_q [BUF_DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [CNT_W-1:0] count_q;
    logic [1:0]       pop_n;

    always_comb begin
        pop_n = 2'd0;
        if (i_pop2) begin
            pop_n = 2'd2;
        end else if (i_pop1) begin
            pop_n = 2'd1;
        end
    end

    // Pointers wrap naturally because BUF_DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (i_push) begin
                wptr_q <= wptr_q + PTR_W'(1);
            end
            rptr_q  <= rptr_q + PTR_W'(pop_n);
            count_q <= count_q + CNT_W'(i_push) - CNT_W'(pop_n);
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            mem_q[wptr_q] <= i_push_data;
        end
    end

    assign o_head0 = mem_q[rptr_q];
    assign o_head1 = mem_q[rptr_q + PTR_W'(1)];
    assign o_count = count_q;

endmodule

// File: rtl/tt_vpu_ovi_store_ctrl.sv
// OVI vector-store controller: buffers vs3 slices, packs them two per 512-bit
// OVI store beat under a credit budget, then runs the memop sync handshake and
// waits for the load queue to empty before signalling completion.
//   i_clk, i_reset          : clock, synchronous active-high reset
//   i_start                 : store begins (honoured only when idle)
//   i_data_vld/i_data/i_last: vs3 slice stream, o_data_rtr is its ready
//   o_store_valid/o_store_data : OVI store beat (one-cycle pulse per beat)
//   i_store_credit          : one store-data credit returned by the CPU
//   o_memop_sync_start      : pulse opening memop sync
//   i_memop_sync_end        : CPU closes memop sync
//   i_lq_empty              : pipeline load queue empty
//   o_commit                : store complete pulse
//   o_busy                  : controller not idle
module tt_vpu_ovi_store_ctrl
    import tt_vpu_ovi_pkg::*;
#(
    parameter int unsigned VLEN          = 256,
    parameter int unsigned BUF_DEPTH     = 8,
    parameter int unsigned STORE_CREDITS = DEFAULT_STORE_CREDITS
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_start,
    input  logic                        i_data_vld,
    input  logic [VLEN-1:0]             i_data,
    input  logic                        i_last,
    output logic                        o_data_rtr,
    output logic                        o_store_valid,
    output logic [OVI_STORE_DATA_W-1:0] o_store_data,
    input  logic                        i_store_credit,
    output logic                        o_memop_sync_start,
    input  logic                        i_memop_sync_end,
    input  logic                        i_lq_empty,
    output logic                        o_commit,
    output logic                        o_busy
);

    localparam int unsigned CNT_W  = $clog2(BUF_DEPTH) + 1;
    localparam int unsigned CRED_W = $clog2(STORE_CREDITS + 1);

    store_state_e              state_q, state_d;
    logic [CRED_W-1:0]         credits_q, credits_d;
    logic                      sync_latch_q, sync_latch_d;
    logic                      last_q, last_d;
    logic                      store_valid_q;
    logic [OVI_STORE_DATA_W-1:0] store_data_q;
    logic                      sync_start_q;
    logic                      commit_q;

    logic [VLEN-1:0]           head0, head1;
    logic [CNT_W-1:0]          count;
    logic                      full, rtr, accept, have_credit, active;
    logic                      pop1, pop2, beat, clear_buf;
    logic [OVI_STORE_DATA_W-1:0] beat_data;

    tt_vpu_store_buf #(
        .VLEN      (VLEN),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_buf (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_clear     (clear_buf),
        .i_push      (accept),
        .i_push_data (i_data),
        .i_pop1      (pop1),
        .i_pop2      (pop2),
        .o_head0     (head0),
        .o_head1     (head1),
        .o_count     (count)
    );

    // Ready depends only on registered state, so a pop never frees a slot
    // for a push in the same cycle.
    always_comb begin
        full        = (count == CNT_W'(BUF_DEPTH));
        rtr         = !full && (state_q inside {StIdle, StCollect, StDrain});
        accept      = i_data_vld && rtr && ((state_q != StIdle) || i_start);
        have_credit = (credits_q != '0);
        active      = (state_q == StCollect) || (state_q == StDrain);
        pop2        = active && have_credit && (count >= CNT_W'(2));
        // A lone entry is only shipped once no partner can still arrive.
        pop1        = (state_q == StDrain) && have_credit && (count == CNT_W'(1));
        beat        = pop1 || pop2;

        beat_data = '0;
        beat_data[VLEN-1:0] = head0;
        if (pop2) begin
            beat_data[OVI_HALF_W +: VLEN] = head1;
        end
    end

    always_comb begin
        credits_d = credits_q;
        unique case ({beat, i_store_credit})
            2'b10: credits_d = credits_q - CRED_W'(1);
            2'b01: begin
                if (credits_q != CRED_W'(STORE_CREDITS)) begin
                    credits_d = credits_q + CRED_W'(1);
                end
            end
            default: credits_d = credits_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        clear_buf = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_start) state_d = StCollect;
            end
            StCollect: begin
                // last_q covers a final slice taken on the start cycle.
                if ((accept && i_last) || last_q) state_d = StDrain;
            end
            StDrain: begin
                if ((count == '0) && !accept && !store_valid_q) state_d = StSync;
            end
            StSync: begin
                if (sync_latch_q || i_memop_sync_end) state_d = StWaitLq;
            end
            StWaitLq: begin
                if (i_lq_empty) begin
                    state_d   = StIdle;
                    clear_buf = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        last_d = clear_buf ? 1'b0 : (last_q || (accept && i_last));

        // sync_end may come early; remember it until SYNC consumes it.
        sync_latch_d = sync_latch_q;
        if (i_memop_sync_end && (state_q inside {StCollect, StDrain, StSync})) begin
            sync_latch_d = 1'b1;
        end
        if ((state_q == StSync) && (state_d != StSync)) begin
            sync_latch_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= StIdle;
            credits_q     <= CRED_W'(STORE_CREDITS);
            sync_latch_q  <= 1'b0;
            last_q        <= 1'b0;
            store_valid_q <= 1'b0;
            store_data_q  <= '0;
            sync_start_q  <= 1'b0;
            commit_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            credits_q     <= credits_d;
            sync_latch_q  <= sync_latch_d;
            last_q        <= last_d;
            store_valid_q <= beat;
            if (beat) begin
                store_data_q <= beat_data;
            end
            sync_start_q  <= (state_q == StIdle) && i_start;
            commit_q      <= (state_q == StWaitLq) && i_lq_empty;
        end
    end

    assign o_data_rtr         = rtr;
    assign o_store_valid      = store_valid_q;
    assign o_store_data       = store_data_q;
    assign o_memop_sync_start = sync_start_q;
    assign o_commit           = commit_q;
    assign o_busy             = (state_q != StIdle);

endmodule

// File: tb/tb_tt_vpu_ovi_store_ctrl.sv
module tb_tt_vpu_ovi_store_ctrl;

    localparam int unsigned VLEN          = 256;
    localparam int unsigned BUF_DEPTH     = 8;
    localparam int unsigned STORE_CREDITS = 32;

    logic             clk;
    logic             i_reset, i_start, i_data_vld, i_last;
    logic [VLEN-1:0]  i_data;
    logic             i_store_credit, man_credit, auto_credit;
    logic             i_memop_sync_end, i_lq_empty;
    logic             o_data_rtr, o_store_valid, o_memop_sync_start, o_commit, o_busy;
    logic [511:0]     o_store_data;

    assign i_store_credit = man_credit | auto_credit;

    tt_vpu_ovi_store_ctrl #(
        .VLEN          (VLEN),
        .BUF_DEPTH     (BUF_DEPTH),
        .STORE_CREDITS (STORE_CREDITS)
    ) dut (
        .i_clk              (clk),
        .i_reset            (i_reset),
        .i_start            (i_start),
        .i_data_vld         (i_data_vld),
        .i_data             (i_data),
        .i_last             (i_last),
        .o_data_rtr         (o_data_rtr),
        .o_store_valid      (o_store_valid),
        .o_store_data       (o_store_data),
        .i_store_credit     (i_store_credit),
        .o_memop_sync_start (o_memop_sync_start),
        .i_memop_sync_end   (i_memop_sync_end),
        .i_lq_empty         (i_lq_empty),
        .o_commit           (o_commit),
        .o_busy             (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int sync_starts = 0;
    int commits = 0;
    int beats_auto = 0;
    int credits_given = 0;
    bit auto_en = 1'b0;

    logic [511:0]    got_q[$];
    logic [511:0]    exp_q[$];
    logic [VLEN-1:0] cur[$];

    typedef struct {
        int n;
        int gap;
        int exp_beats;
    } vec_t;
    vec_t tbl[5];

    // Output monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (!i_reset) begin
            if (o_store_valid) begin
                got_q.push_back(o_store_data);
                if (auto_en) beats_auto++;
            end
            if (o_memop_sync_start) sync_starts++;
            if (o_commit) commits++;
        end
    end

    // CPU model for the random phase: returns one credit per received beat.
    always @(posedge clk) begin
        #2;
        if (auto_en && (beats_auto > credits_given) && ($urandom_range(0, 2) == 0)) begin
            auto_credit = 1'b1;
            credits_given++;
        end else begin
            auto_credit = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        repeat (2) tick();
        i_reset = 1'b0;
    endtask

    task automatic pulse_credit();
        man_credit = 1'b1;
        tick();
        man_credit = 1'b0;
    endtask

    function automatic logic [VLEN-1:0] rand_slice();
        logic [VLEN-1:0] r;
        for (int i = 0; i < int'(VLEN / 32); i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference packing: slices pair up in arrival order, an odd tail ships alone.
    task automatic model_store();
        for (int i = 0; i < cur.size(); i += 2) begin
            logic [511:0] b;
            b = '0;
            b[VLEN-1:0] = cur[i];
            if (i + 1 < cur.size()) b[256 +: VLEN] = cur[i+1];
            exp_q.push_back(b);
        end
    endtask

    task automatic send_slice(input logic [VLEN-1:0] d, input bit last, input bit start);
        bit r;
        bit done;
        done = 1'b0;
        i_data = d;
        i_data_vld = 1'b1;
        i_last = last;
        i_start = start;
        for (int c = 0; c < 500 && !done; c++) begin
            r = o_data_rtr;
            tick();
            i_start = 1'b0;
            if (r) done = 1'b1;
        end
        check_int("send_slice_accepted", int'(done), 1);
        i_data_vld = 1'b0;
        i_last = 1'b0;
    endtask

    task automatic send_store(input int n, input int max_gap);
        cur.delete();
        for (int i = 0; i < n; i++) begin
            logic [VLEN-1:0] d;
            d = rand_slice();
            cur.push_back(d);
            send_slice(d, (i == n - 1), (i == 0));
            repeat ($urandom_range(0, max_gap)) tick();
        end
        model_store();
    endtask

    task automatic close_store(input string name);
        int c0;
        int cyc;
        c0 = commits;
        cyc = 0;
        i_memop_sync_end = 1'b1;
        tick();
        i_memop_sync_end = 1'b0;
        while (commits == c0 && cyc < 3000) begin
            tick();
            cyc++;
        end
        repeat (3) tick();
        check_int({name, "_commit"}, commits - c0, 1);
        check_int({name, "_idle"}, int'(o_busy), 0);
    endtask

    task automatic compare_beats(input string name);
        check_int({name, "_beat_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL %s_beat%0d: got %h expected %h", name, i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int ss0;
        int c0;
        int nb;
        logic [VLEN-1:0] d;

        i_reset = 1'b1; i_start = 1'b0; i_data_vld = 1'b0; i_last = 1'b0;
        i_data = '0; man_credit = 1'b0; auto_credit = 1'b0;
        i_memop_sync_end = 1'b0; i_lq_empty = 1'b1;
        repeat (3) tick();
        i_reset = 1'b0;
        tick();

        // Reset state
        check_int("rst_busy", int'(o_busy), 0);
        check_int("rst_rtr", int'(o_data_rtr), 1);
        check_int("rst_valid", int'(o_store_valid), 0);
        check_int("rst_sync_start", int'(o_memop_sync_start), 0);
        check_int("rst_commit", int'(o_commit), 0);
        check_int("rst_data_zero", int'(o_store_data == '0), 1);

        // Table-driven stores: slice count, gap, expected beat count
        tbl[0] = '{n: 1, gap: 0, exp_beats: 1};
        tbl[1] = '{n: 2, gap: 0, exp_beats: 1};
        tbl[2] = '{n: 3, gap: 1, exp_beats: 2};
        tbl[3] = '{n: 8, gap: 0, exp_beats: 4};
        tbl[4] = '{n: 5, gap: 2, exp_beats: 3};
        for (int t = 0; t < 5; t++) begin
            ss0 = sync_starts;
            send_store(tbl[t].n, tbl[t].gap);
            close_store($sformatf("tbl%0d", t));
            check_int($sformatf("tbl%0d_nbeats", t), got_q.size(), tbl[t].exp_beats);
            check_int($sformatf("tbl%0d_sync_start", t), sync_starts - ss0, 1);
            compare_beats($sformatf("tbl%0d", t));
        end

        // Randomized stores with a credit-returning CPU
        auto_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            send_store($urandom_range(1, 14), $urandom_range(0, 3));
            close_store($sformatf("rnd%0d", k));
            compare_beats($sformatf("rnd%0d", k));
        end
        for (int c = 0; c < 500 && beats_auto != credits_given; c++) tick();
        check_int("rnd_credits_returned", credits_given, beats_auto);
        auto_en = 1'b0;
        tick();

        // Credit exhaustion: leave exactly one credit
        do_reset();
        send_store(62, 0);
        close_store("burn31");
        compare_beats("burn31");
        send_store(6, 0);
        repeat (20) tick();
        check_int("one_credit_one_beat", got_q.size(), 1);
        for (int r = 0; r < 2; r++) begin
            pulse_credit();
            repeat (15) tick();
            check_int($sformatf("credit_release%0d", r), got_q.size(), 2 + r);
        end
        close_store("starve");
        compare_beats("starve");

        // Zero credits: buffer fills and ready drops, no data lost
        fork
            send_store(9, 0);
            begin
                repeat (30) tick();
                check_int("full_rtr_low", int'(o_data_rtr), 0);
                check_int("full_no_beat", got_q.size(), 0);
                for (int r = 0; r < 5; r++) begin
                    pulse_credit();
                    repeat (10) tick();
                end
            end
        join
        close_store("fullbuf");
        compare_beats("fullbuf");

        // Reset in DRAIN with 3 stranded entries
        c0 = commits;
        send_store(3, 0);
        repeat (10) tick();
        check_int("drain_stuck_no_beat", got_q.size(), 0);
        check_int("drain_stuck_busy", int'(o_busy), 1);
        do_reset();
        tick();
        check_int("mid_rst_busy", int'(o_busy), 0);
        check_int("mid_rst_rtr", int'(o_data_rtr), 1);
        repeat (30) tick();
        check_int("mid_rst_no_beat", got_q.size(), 0);
        check_int("mid_rst_no_commit", commits - c0, 0);
        got_q.delete();
        exp_q.delete();
        send_store(64, 0);
        close_store("full_credits");
        compare_beats("full_credits");

        // Beat and credit return in the same cycle at one credit
        pulse_credit();
        cur.delete();
        for (int i = 0; i < 4; i++) begin
            d = rand_slice();
            cur.push_back(d);
            if (i == 2) man_credit = 1'b1;
            send_slice(d, (i == 3), (i == 0));
            man_credit = 1'b0;
        end
        model_store();
        repeat (20) tick();
        check_int("simul_credit_beats", got_q.size(), 2);
        close_store("simul");
        compare_beats("simul");
        send_store(2, 0);
        repeat (20) tick();
        check_int("simul_then_empty", got_q.size(), 0);
        pulse_credit();
        close_store("simul_tail");
        compare_beats("simul_tail");

        // Early sync_end during COLLECT, and commit held off by the load queue
        pulse_credit();
        i_lq_empty = 1'b0;
        c0 = commits;
        cur.delete();
        d = rand_slice();
        cur.push_back(d);
        send_slice(d, 1'b0, 1'b1);
        check_int("sync_start_next_cycle", int'(o_memop_sync_start), 1);
        i_memop_sync_end = 1'b1;
        tick();
        i_memop_sync_end = 1'b0;
        check_int("sync_start_one_cycle", int'(o_memop_sync_start), 0);
        d = rand_slice();
        cur.push_back(d);
        send_slice(d, 1'b1, 1'b0);
        model_store();
        repeat (30) tick();
        check_int("lq_busy_no_commit", commits - c0, 0);
        check_int("lq_busy_still_busy", int'(o_busy), 1);
        i_lq_empty = 1'b1;
        nb = 0;
        while (commits == c0 && nb < 100) begin
            tick();
            nb++;
        end
        repeat (3) tick();
        check_int("early_sync_commit", commits - c0, 1);
        compare_beats("early_sync");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
